// File: rtl/timer_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg
// Shared definitions for the stopwatch-style BCD timer: FSM state encoding,
// the BCD digit type, digit wrap limits and helpers that split a binary
// value into BCD tens/ones digits.
// Ports: none (package).
// -----------------------------------------------------------------------------
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } timer_state_e;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t SEC_TENS_MAX = 4'd5;
    localparam bcd_digit_t DIGIT_MAX    = 4'd9;

    // Tens digit of a 0..99 value.
    function automatic bcd_digit_t tens_of(input int value);
        return bcd_digit_t'((value / 32'sd10) % 32'sd10);
    endfunction

    // Ones digit of a 0..99 value.
    function automatic bcd_digit_t ones_of(input int value);
        return bcd_digit_t'(value % 32'sd10);
    endfunction

endpackage

// File: rtl/bcd_digit_cnt.sv
// -----------------------------------------------------------------------------
// bcd_digit_cnt
// One BCD digit counting 0..WRAP. Chained through carry to build the
// seconds/minutes display.
// Parameters: WRAP  - last value before the digit returns to 0 (<= 9).
// Ports:
//   clk   in  clock
//   rst   in  synchronous active-high reset
//   clr   in  synchronous clear (wins over inc)
//   inc   in  advance the digit by one
//   value out current digit
//   carry out high when inc is applied while the digit sits at WRAP
// -----------------------------------------------------------------------------
module bcd_digit_cnt
    import timer_pkg::*;
#(
    parameter bcd_digit_t WRAP = DIGIT_MAX
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    output bcd_digit_t value,
    output logic       carry
);

    bcd_digit_t value_r;

    // Digit register: reset/clear to zero, wrap at WRAP, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            value_r <= 4'd0;
        end else if (clr) begin
            value_r <= 4'd0;
        end else if (inc) begin
            value_r <= (value_r == WRAP) ? 4'd0 : value_r + 4'd1;
        end else begin
            value_r <= value_r;
        end
    end

    assign value = value_r;
    assign carry = inc & (value_r == WRAP);

endmodule

// File: rtl/timer_bcd_counter.sv
// -----------------------------------------------------------------------------
// timer_bcd_counter
// Run/pause/clear stopwatch counting MM:SS in BCD from a divided timer clock.
// timer_clk is sampled as data; its rising edges in RUN are ticks, and every
// TICKS_PER_SEC ticks the seconds advance. The display wraps from
// MAX_MINUTES:59 to 00:00 with a one-cycle rollover pulse.
//
// Optional feature macro: TIMER_LAP_EN adds a lap input that freezes the
// displayed digits (lap_active high) while counting continues internally.
//
// Parameters: TICKS_PER_SEC (2..15), MAX_MINUTES (1..99)
// Ports:
//   sys_clk      in   clock
//   int_reset    in   synchronous active-high reset
//   timer_clk    in   divided clock, sampled as data
//   start_stop   in   pulse, toggles run/pause
//   clear        in   pulse, zero the time and return to IDLE
//   lap          in   (TIMER_LAP_EN) pulse, toggles display freeze
//   lap_active   out  (TIMER_LAP_EN) display frozen
//   timer_clear  out  clock-generator clear, one cycle after clear
//   timer_pause  out  clock-generator pause, high unless running
//   sec_ones/sec_tens/min_ones/min_tens  out  BCD display digits
//   running      out  high in RUN
//   rollover     out  one-cycle pulse on MAX_MINUTES:59 -> 00:00
// -----------------------------------------------------------------------------
module timer_bcd_counter
    import timer_pkg::*;
#(
    parameter int TICKS_PER_SEC = 10,
    parameter int MAX_MINUTES   = 59
) (
    input  logic       sys_clk,
    input  logic       int_reset,
    input  logic       timer_clk,
    input  logic       start_stop,
    input  logic       clear,
`ifdef TIMER_LAP_EN
    input  logic       lap,
    output logic       lap_active,
`endif
    output logic       timer_clear,
    output logic       timer_pause,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       running,
    output logic       rollover
);

    localparam logic [3:0] SUB_LAST   = 4'(TICKS_PER_SEC - 1);
    localparam bcd_digit_t MAX_TENS_D = tens_of(MAX_MINUTES);
    localparam bcd_digit_t MAX_ONES_D = ones_of(MAX_MINUTES);

    timer_state_e state_r;
    timer_state_e state_next_s;
    logic         timer_clk_q_r;
    logic         timer_clear_r;
    logic         timer_pause_r;
    logic         running_r;
    logic         rollover_r;
    logic [3:0]   sub_r;

    logic         tick_s;
    logic         sub_wrap_s;
    logic         sec_step_s;
    logic         at_max_s;
    logic         rollover_s;
    logic         digit_clr_s;

    bcd_digit_t   live_sec_ones_s;
    bcd_digit_t   live_sec_tens_s;
    bcd_digit_t   live_min_ones_s;
    bcd_digit_t   live_min_tens_s;
    logic         sec_ones_carry_s;
    logic         sec_tens_carry_s;
    logic         min_ones_carry_s;
    logic         min_tens_carry_s;
    logic [15:0]  live_time_s;
    logic [15:0]  shown_time_s;

    // Next-state logic; clear dominates start_stop.
    always_comb begin
        state_next_s = state_r;
        if (clear) begin
            state_next_s = IDLE;
        end else if (start_stop) begin
            case (state_r)
                IDLE:    state_next_s = RUN;
                RUN:     state_next_s = PAUSED;
                PAUSED:  state_next_s = RUN;
                default: state_next_s = IDLE;
            endcase
        end else begin
            state_next_s = state_r;
        end
    end

    // State register plus the outputs decoded from the next state, so they
    // change on the same edge as the state.
    always_ff @(posedge sys_clk) begin
        if (int_reset) begin
            state_r       <= IDLE;
            timer_pause_r <= 1'b1;
            running_r     <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            timer_pause_r <= (state_next_s != RUN);
            running_r     <= (state_next_s == RUN);
        end
    end

    // timer_clk history for edge detection and the one-cycle generator clear.
    always_ff @(posedge sys_clk) begin
        if (int_reset) begin
            timer_clk_q_r <= 1'b0;
            timer_clear_r <= 1'b1;
        end else begin
            timer_clk_q_r <= timer_clk;
            timer_clear_r <= clear;
        end
    end

    // Edges seen outside RUN are simply dropped, never queued.
    assign tick_s     = timer_clk & ~timer_clk_q_r & (state_r == RUN);
    assign sub_wrap_s = (sub_r == SUB_LAST);
    assign sec_step_s = tick_s & sub_wrap_s;

    // Sub-second tick counter.
    always_ff @(posedge sys_clk) begin
        if (int_reset) begin
            sub_r <= 4'd0;
        end else if (clear) begin
            sub_r <= 4'd0;
        end else if (tick_s) begin
            sub_r <= sub_wrap_s ? 4'd0 : sub_r + 4'd1;
        end else begin
            sub_r <= sub_r;
        end
    end

    // Wrap of the whole display happens when seconds carry into minutes
    // while minutes already sit at MAX_MINUTES. A carry out of min_tens can
    // only mean 99:59, which is a wrap as well.
    assign at_max_s    = (live_min_tens_s == MAX_TENS_D) && (live_min_ones_s == MAX_ONES_D);
    assign rollover_s  = (sec_tens_carry_s & at_max_s) | min_tens_carry_s;
    assign digit_clr_s = clear | rollover_s;

    bcd_digit_cnt #(.WRAP(DIGIT_MAX)) u_sec_ones (
        .clk(sys_clk), .rst(int_reset), .clr(digit_clr_s), .inc(sec_step_s),
        .value(live_sec_ones_s), .carry(sec_ones_carry_s)
    );

    bcd_digit_cnt #(.WRAP(SEC_TENS_MAX)) u_sec_tens (
        .clk(sys_clk), .rst(int_reset), .clr(digit_clr_s), .inc(sec_ones_carry_s),
        .value(live_sec_tens_s), .carry(sec_tens_carry_s)
    );

    bcd_digit_cnt #(.WRAP(DIGIT_MAX)) u_min_ones (
        .clk(sys_clk), .rst(int_reset), .clr(digit_clr_s), .inc(sec_tens_carry_s),
        .value(live_min_ones_s), .carry(min_ones_carry_s)
    );

    bcd_digit_cnt #(.WRAP(DIGIT_MAX)) u_min_tens (
        .clk(sys_clk), .rst(int_reset), .clr(digit_clr_s), .inc(min_ones_carry_s),
        .value(live_min_tens_s), .carry(min_tens_carry_s)
    );

    // Rollover pulse; a simultaneous clear already zeroes the display.
    always_ff @(posedge sys_clk) begin
        if (int_reset) begin
            rollover_r <= 1'b0;
        end else begin
            rollover_r <= rollover_s & ~clear;
        end
    end

    assign live_time_s = {live_min_tens_s, live_min_ones_s, live_sec_tens_s, live_sec_ones_s};

`ifdef TIMER_LAP_EN
    logic        lap_active_r;
    logic [15:0] frozen_time_r;

    // Lap freeze: first lap captures the live display, second releases it.
    always_ff @(posedge sys_clk) begin
        if (int_reset) begin
            lap_active_r  <= 1'b0;
            frozen_time_r <= 16'd0;
        end else if (clear) begin
            lap_active_r  <= 1'b0;
            frozen_time_r <= frozen_time_r;
        end else if (lap && (state_r != IDLE)) begin
            lap_active_r  <= ~lap_active_r;
            frozen_time_r <= lap_active_r ? frozen_time_r : live_time_s;
        end else begin
            lap_active_r  <= lap_active_r;
            frozen_time_r <= frozen_time_r;
        end
    end

    assign shown_time_s = lap_active_r ? frozen_time_r : live_time_s;
    assign lap_active   = lap_active_r;
`else
    assign shown_time_s = live_time_s;
`endif

    assign min_tens    = shown_time_s[15:12];
    assign min_ones    = shown_time_s[11:8];
    assign sec_tens    = shown_time_s[7:4];
    assign sec_ones    = shown_time_s[3:0];
    assign timer_clear = timer_clear_r;
    assign timer_pause = timer_pause_r;
    assign running     = running_r;
    assign rollover    = rollover_r;

endmodule

// File: tb/tb_timer_bcd_counter.sv
// -----------------------------------------------------------------------------
// tb_timer_bcd_counter
// Drives two instances (default parameters, and a fast TICKS_PER_SEC=2 /
// MAX_MINUTES=1 build for wrap behaviour) with the same inputs. A reference
// model tracks elapsed ticks as a plain integer and derives the expected
// MM:SS display arithmetically; all outputs are compared every cycle.
// Directed scenarios are followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_timer_bcd_counter;

    localparam int TPS0 = 10;
    localparam int MAX0 = 59;
    localparam int TPS1 = 2;
    localparam int MAX1 = 1;
`ifdef TIMER_LAP_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif

    localparam int M_IDLE   = 0;
    localparam int M_RUN    = 1;
    localparam int M_PAUSED = 2;

    logic sys_clk = 1'b0;
    logic int_reset, timer_clk, start_stop, clear;
`ifdef TIMER_LAP_EN
    logic lap;
    logic lap_act0, lap_act1;
`endif
    logic       tclr0, tp0, run0, roll0;
    logic       tclr1, tp1, run1, roll1;
    logic [3:0] so0, st0, mo0, mt0;
    logic [3:0] so1, st1, mo1, mt1;

    int checks   = 0;
    int failures = 0;
    int roll1_cnt;

    // reference model state
    int m_mode;
    bit m_tq, m_tclr, m_lap;
    int m_ticks [2];
    int m_frz   [2];
    bit m_roll  [2];

    always #5 sys_clk = ~sys_clk;

    timer_bcd_counter #(.TICKS_PER_SEC(TPS0), .MAX_MINUTES(MAX0)) dut0 (
        .sys_clk(sys_clk), .int_reset(int_reset), .timer_clk(timer_clk),
        .start_stop(start_stop), .clear(clear),
`ifdef TIMER_LAP_EN
        .lap(lap), .lap_active(lap_act0),
`endif
        .timer_clear(tclr0), .timer_pause(tp0),
        .sec_ones(so0), .sec_tens(st0), .min_ones(mo0), .min_tens(mt0),
        .running(run0), .rollover(roll0)
    );

    timer_bcd_counter #(.TICKS_PER_SEC(TPS1), .MAX_MINUTES(MAX1)) dut1 (
        .sys_clk(sys_clk), .int_reset(int_reset), .timer_clk(timer_clk),
        .start_stop(start_stop), .clear(clear),
`ifdef TIMER_LAP_EN
        .lap(lap), .lap_active(lap_act1),
`endif
        .timer_clear(tclr1), .timer_pause(tp1),
        .sec_ones(so1), .sec_tens(st1), .min_ones(mo1), .min_tens(mt1),
        .running(run1), .rollover(roll1)
    );

    function automatic int tps_of(input int d);
        return (d == 0) ? TPS0 : TPS1;
    endfunction

    function automatic int period_of(input int d);
        return (d == 0) ? TPS0 * 60 * (MAX0 + 1) : TPS1 * 60 * (MAX1 + 1);
    endfunction

    // Expected MM:SS as four packed BCD nibbles from an elapsed tick count.
    function automatic logic [31:0] exp_digits(input int t, input int tps);
        int secs, mm, sec_v;
        secs  = t / tps;
        mm    = secs / 60;
        sec_v = secs % 60;
        return {16'd0, 4'(mm / 10), 4'(mm % 10), 4'(sec_v / 10), 4'(sec_v % 10)};
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // Advance the reference model by one sys_clk edge.
    task automatic model_step(input bit r, input bit ss, input bit cl, input bit tc, input bit lp);
        bit tick;
        if (r) begin
            m_mode = M_IDLE; m_tq = 1'b0; m_tclr = 1'b1; m_lap = 1'b0;
            for (int d = 0; d < 2; d++) begin
                m_ticks[d] = 0; m_roll[d] = 1'b0; m_frz[d] = 0;
            end
        end else begin
            tick   = tc && !m_tq && (m_mode == M_RUN);
            m_tq   = tc;
            m_tclr = cl;
            for (int d = 0; d < 2; d++) m_roll[d] = 1'b0;
            if (cl) begin
                m_mode = M_IDLE;
                m_lap  = 1'b0;
                for (int d = 0; d < 2; d++) m_ticks[d] = 0;
            end else begin
                if (LAP_EN && lp && (m_mode != M_IDLE)) begin
                    if (!m_lap) for (int d = 0; d < 2; d++) m_frz[d] = m_ticks[d];
                    m_lap = !m_lap;
                end
                if (tick) begin
                    for (int d = 0; d < 2; d++) begin
                        m_ticks[d]++;
                        if (m_ticks[d] == period_of(d)) begin
                            m_ticks[d] = 0;
                            m_roll[d]  = 1'b1;
                        end
                    end
                end
                if (ss) m_mode = (m_mode == M_RUN) ? M_PAUSED : M_RUN;
            end
        end
    endtask

    task automatic compare_all();
        int disp0, disp1;
        disp0 = m_lap ? m_frz[0] : m_ticks[0];
        disp1 = m_lap ? m_frz[1] : m_ticks[1];
        check_val("digits0", 32'({mt0, mo0, st0, so0}), exp_digits(disp0, tps_of(0)));
        check_val("digits1", 32'({mt1, mo1, st1, so1}), exp_digits(disp1, tps_of(1)));
        check_val("running0", 32'(run0), 32'(m_mode == M_RUN));
        check_val("running1", 32'(run1), 32'(m_mode == M_RUN));
        check_val("pause0", 32'(tp0), 32'(m_mode != M_RUN));
        check_val("pause1", 32'(tp1), 32'(m_mode != M_RUN));
        check_val("tclear0", 32'(tclr0), 32'(m_tclr));
        check_val("tclear1", 32'(tclr1), 32'(m_tclr));
        check_val("rollover0", 32'(roll0), 32'(m_roll[0]));
        check_val("rollover1", 32'(roll1), 32'(m_roll[1]));
`ifdef TIMER_LAP_EN
        check_val("lap_active0", 32'(lap_act0), 32'(m_lap));
        check_val("lap_active1", 32'(lap_act1), 32'(m_lap));
`endif
    endtask

    // One sys_clk cycle: drive inputs, step model, sample after the edge.
    task automatic cyc(input bit r, input bit ss, input bit cl, input bit tc, input bit lp);
        int_reset  = r;
        start_stop = ss;
        clear      = cl;
        timer_clk  = tc;
`ifdef TIMER_LAP_EN
        lap        = lp;
`endif
        model_step(r, ss, cl, tc, lp);
        @(posedge sys_clk);
        #1;
        if (roll1 === 1'b1) roll1_cnt++;
        compare_all();
    endtask

    task automatic idle_cyc();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic restart();
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        roll1_cnt = 0;

        // reset state
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        check_val("rst_tclear", 32'(tclr0), 32'd1);
        check_val("rst_pause", 32'(tp0), 32'd1);
        check_val("rst_digits", 32'({mt0, mo0, st0, so0}), 32'd0);
        idle_cyc();
        check_val("tclear_fall", 32'(tclr0), 32'd0);

        // one second after start
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick_n(10);
        check_val("one_sec_digits", 32'({mt0, mo0, st0, so0}), 32'h0001);
        check_val("one_sec_running", 32'(run0), 32'd1);
        check_val("one_sec_pause", 32'(tp0), 32'd0);

        // 00:59 + 9 sub-ticks, then the minute carry
        restart();
        roll1_cnt = 0;
        tick_n(599);
        check_val("pre_min_digits", 32'({mt0, mo0, st0, so0}), 32'h0059);
        tick_n(1);
        check_val("min_carry_digits", 32'({mt0, mo0, st0, so0}), 32'h0100);
        check_val("fast_rollover_count", 32'(roll1_cnt), 32'd2);

        // wrap 01:59 -> 00:00 on the MAX_MINUTES=1 build
        restart();
        tick_n(239);
        check_val("pre_wrap_digits", 32'({mt1, mo1, st1, so1}), 32'h0159);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_val("wrap_digits", 32'({mt1, mo1, st1, so1}), 32'h0000);
        check_val("wrap_pulse", 32'(roll1), 32'd1);
        idle_cyc();
        check_val("wrap_pulse_end", 32'(roll1), 32'd0);

        // pause holds the display and discards ticks
        restart();
        tick_n(70);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick_n(30);
        check_val("paused_digits", 32'({mt0, mo0, st0, so0}), 32'h0007);
        check_val("paused_pause", 32'(tp0), 32'd1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick_n(10);
        check_val("resumed_digits", 32'({mt0, mo0, st0, so0}), 32'h0008);

        // clear beats start_stop and a same-cycle tick
        restart();
        tick_n(120);
        check_val("pre_clear_digits", 32'({mt0, mo0, st0, so0}), 32'h0012);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        check_val("clear_running", 32'(run0), 32'd0);
        check_val("clear_digits", 32'({mt0, mo0, st0, so0}), 32'h0000);
        check_val("clear_tclear", 32'(tclr0), 32'd1);
        idle_cyc();
        check_val("clear_tclear_end", 32'(tclr0), 32'd0);

        // reset mid-count overrides everything
        restart();
        tick_n(15);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        check_val("midrst_digits", 32'({mt0, mo0, st0, so0}), 32'h0000);
        check_val("midrst_running", 32'(run0), 32'd0);
        idle_cyc();

`ifdef TIMER_LAP_EN
        // lap freeze / release, and lap ignored in IDLE
        restart();
        tick_n(30);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick_n(20);
        check_val("lap_frozen_digits", 32'({mt0, mo0, st0, so0}), 32'h0003);
        check_val("lap_frozen_flag", 32'(lap_act0), 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_val("lap_release_digits", 32'({mt0, mo0, st0, so0}), 32'h0005);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_val("lap_idle_flag", 32'(lap_act0), 32'd0);
`endif

        // randomized phase
        for (int i = 0; i < 4000; i++) begin
            bit r, ss, cl, tc, lp;
            r  = ($urandom % 500) == 0;
            ss = ($urandom % 40) == 0;
            cl = ($urandom % 150) == 0;
            tc = $urandom % 2;
            lp = LAP_EN && (($urandom % 60) == 0);
            cyc(r, ss, cl, tc, lp);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/timer_bcd_counter.md
TIMER_BCD_COUNTER -- requirements
Module: timer_bcd_counter

Interface
REQ-001 Parameter TICKS_PER_SEC, default 10: timer_clk rising edges per elapsed second; legal range 2..15.
REQ-002 Parameter MAX_MINUTES, default 59: highest minute value before wrap; legal range 1..99.
REQ-003 sys_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 int_reset  input  1  synchronous, active-high reset, sampled on the sys_clk rising edge.
REQ-005 timer_clk  input  1  divided clock from the timer clock generator, synchronous to sys_clk; sampled as data only, never used as a clock.
REQ-006 start_stop  input  1  single-cycle pulse; toggles run/pause.
REQ-007 clear  input  1  single-cycle pulse; zeroes the time and returns to IDLE.
REQ-008 timer_clear  output  1  drives the clock generator's clear input.
REQ-009 timer_pause  output  1  drives the clock generator's pause input.
REQ-010 sec_ones, sec_tens, min_ones, min_tens  output  4 each  BCD digits of the displayed time.
REQ-011 running  output  1  high while in RUN.
REQ-012 rollover  output  1  single-cycle pulse on wrap from MAX_MINUTES:59 to 00:00.
REQ-013 lap  input  1, and lap_active  output  1, SHALL exist only when TIMER_LAP_EN is defined.

Function
REQ-014 FSM states: IDLE, RUN, PAUSED.
REQ-015 Transitions: IDLE+start_stop->RUN; RUN+start_stop->PAUSED; PAUSED+start_stop->RUN; clear in any state->IDLE.
REQ-016 If clear and start_stop arrive in the same cycle, clear SHALL win and start_stop SHALL be ignored.
REQ-017 timer_pause SHALL be 1 in IDLE and PAUSED and 0 in RUN.
REQ-018 running SHALL equal (state==RUN).
REQ-019 timer_clear SHALL be registered, high for exactly the one cycle after clear is sampled, and low otherwise.
REQ-020 Tick detection: timer_clk SHALL be registered as timer_clk_q. A tick occurs when timer_clk=1, timer_clk_q=0 and state==RUN.
REQ-021 Ticks sampled outside RUN SHALL be discarded and SHALL NOT be queued.
REQ-022 Sub-second counter: range 0..TICKS_PER_SEC-1, incremented on each tick. On wrap it SHALL zero and advance seconds by one in the same cycle.
REQ-023 Seconds SHALL count 00..59 in BCD: sec_ones wraps 9->0 and carries into sec_tens; sec_tens wraps 5->0 and carries into minutes.
REQ-024 Minutes SHALL count 00..MAX_MINUTES in BCD. On a carry at MAX_MINUTES:59, all digits SHALL go to 0 and rollover SHALL pulse for one cycle.
REQ-025 Latency: digit outputs SHALL reflect the new value on the cycle after the sys_clk edge that detects the tick.
REQ-026 Non-BCD digit values (>9) SHALL never be produced.
REQ-027 clear SHALL zero the digits and the sub-second counter on the next edge, even if a tick is detected in the same cycle.
REQ-028 PAUSED SHALL hold the digits and the sub-second counter unchanged.

Reset
REQ-029 On int_reset: state=IDLE; all digits=0; sub-second counter=0; timer_clk_q=0.
REQ-030 On int_reset: timer_pause=1, timer_clear=1, running=0, rollover=0, lap_active=0.
REQ-031 timer_clear SHALL remain 1 on the first cycle after int_reset deasserts, then fall to 0.
REQ-032 Reset asserted mid-count SHALL override every other input in that cycle.

Configuration
REQ-033 Macro TIMER_LAP_EN defined: a lap pulse in RUN or PAUSED SHALL freeze the digit outputs at their current value and set lap_active, while counting continues internally.
REQ-034 With TIMER_LAP_EN, a second lap pulse SHALL release the freeze and clear lap_active.
REQ-035 With TIMER_LAP_EN, clear SHALL also release the freeze.
REQ-036 With TIMER_LAP_EN, lap in IDLE SHALL be ignored.
REQ-037 Macro TIMER_LAP_EN undefined: no lap/lap_active ports, no freeze register; digit outputs always show the live count.

Structure
REQ-038 A shared package timer_pkg SHALL hold the FSM state enum (IDLE/RUN/PAUSED), the BCD digit typedef (4-bit), and constants SEC_TENS_MAX=5 and DIGIT_MAX=9.
REQ-039 A single sub-module bcd_digit_cnt SHALL be used: one BCD digit with increment enable, parameterised wrap value, carry out and synchronous clear. It is instantiated four times in a chain.

Verification
REQ-040 Reset, start_stop, then 10 timer_clk rising edges (TICKS_PER_SEC=10) -> sec_ones=1, all other digits 0, running=1, timer_pause=0.
REQ-041 Run to 00:59 plus 9 sub-ticks, then 1 tick -> min_ones=1, sec_tens=0, sec_ones=0.
REQ-042 MAX_MINUTES=1, run to 01:59 plus 9 sub-ticks, then 1 tick -> digits 00:00, rollover high for exactly 1 cycle.
REQ-043 At 00:07, pulse start_stop, apply 30 timer_clk edges, pulse start_stop again -> digits stay 00:07 while paused; timer_pause=1 while paused; count resumes afterwards.
REQ-044 clear and start_stop in the same cycle while in RUN at 00:12 -> state IDLE, digits 00:00, timer_clear high for 1 cycle, running=0.
REQ-045 TIMER_LAP_EN: lap at 00:03, run 20 more ticks -> outputs show 00:03 and lap_active=1; a second lap -> outputs show 00:05.
